// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Operands are registered onto the ALU and the result returns on one tagged response channel.
module alu_arbiter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned OPW      = 3,
   parameter int unsigned EQ_FIXUP = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic [OPW-1:0]   req0_op_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   input  logic [OPW-1:0]   req1_op_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic             rsp_id_o,
   output logic [WIDTH-1:0] rsp_data_o,
   output logic             rsp_zero_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [OPW-1:0]   alu_op_o,
   input  logic [WIDTH-1:0] alu_res_i,
   output logic             busy_o
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   localparam logic [OPW-1:0] OpEq = '1;

   state_e           state_q, state_d;
   logic             rr_q, rr_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_valid_q, rsp_valid_d;

   logic             gnt_valid;
   logic             gnt_id;
   logic [WIDTH-1:0] result;

   // Grant follows rr_q only under contention; a lone requester always wins.
   always_comb begin
      gnt_id = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         gnt_id = rr_q;
      end else if (req1_valid_i) begin
         gnt_id = 1'b1;
      end
      gnt_valid = (state_q == StIdle) && (req0_valid_i || req1_valid_i);
   end

   assign req0_ready_o = gnt_valid && !gnt_id;
   assign req1_ready_o = gnt_valid &&  gnt_id;

   // The ALU returns 0 for the equal opcode, so the compare is done here.
   always_comb begin
      result = alu_res_i;
      if ((EQ_FIXUP != 0) && (alu_op_q == OpEq)) begin
         result = {{(WIDTH-1){1'b0}}, (alu_a_q == alu_b_q)};
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      id_d        = id_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_valid_d = rsp_valid_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               alu_a_d  = gnt_id ? req1_a_i  : req0_a_i;
               alu_b_d  = gnt_id ? req1_b_i  : req0_b_i;
               alu_op_d = gnt_id ? req1_op_i : req0_op_i;
               id_d     = gnt_id;
               state_d  = StExec;
            end
         end
         StExec: begin
            rsp_data_d  = result;
            rsp_zero_d  = (result == '0);
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rr_d        = ~rsp_id_q;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rr_q        <= 1'b0;
         id_q        <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         rsp_zero_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         id_q        <= id_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign alu_a_o     = alu_a_q;
   assign alu_b_o     = alu_b_q;
   assign alu_op_o    = alu_op_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_zero_o  = rsp_zero_q;
   assign rsp_valid_o = rsp_valid_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus reset and contention sequences.
// A second instance with EQ_FIXUP=0 sees the same stimulus.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       v0, v1, rsp_rdy;
   logic [7:0] a0, b0, a1, b1;
   logic [2:0] op0, op1;

   logic       r0, r1, rv, rid, rz, busy;
   logic [7:0] rdata, alu_a, alu_b, alu_res;
   logic [2:0] alu_op;
   logic       nr0, nr1, nrv, nrid, nrz, nbusy;
   logic [7:0] nrdata, nalu_a, nalu_b, nalu_res;
   logic [2:0] nalu_op;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return (b >= 8) ? 8'h00 : (a << b[2:0]);
         3'd3: return (b >= 8) ? 8'h00 : (a >> b[2:0]);
         3'd4: return a & b;
         3'd5: return a | b;
         3'd6: return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_res  = alu_f(alu_a, alu_b, alu_op);
   assign nalu_res = alu_f(nalu_a, nalu_b, nalu_op);

   alu_arbiter #(.WIDTH(8), .OPW(3), .EQ_FIXUP(1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(v0), .req0_ready_o(r0), .req0_a_i(a0), .req0_b_i(b0), .req0_op_i(op0),
      .req1_valid_i(v1), .req1_ready_o(r1), .req1_a_i(a1), .req1_b_i(b1), .req1_op_i(op1),
      .rsp_valid_o(rv), .rsp_ready_i(rsp_rdy), .rsp_id_o(rid), .rsp_data_o(rdata),
      .rsp_zero_o(rz), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
      .alu_res_i(alu_res), .busy_o(busy)
   );

   alu_arbiter #(.WIDTH(8), .OPW(3), .EQ_FIXUP(0)) dut_nf (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(v0), .req0_ready_o(nr0), .req0_a_i(a0), .req0_b_i(b0), .req0_op_i(op0),
      .req1_valid_i(v1), .req1_ready_o(nr1), .req1_a_i(a1), .req1_b_i(b1), .req1_op_i(op1),
      .rsp_valid_o(nrv), .rsp_ready_i(rsp_rdy), .rsp_id_o(nrid), .rsp_data_o(nrdata),
      .rsp_zero_o(nrz), .alu_a_o(nalu_a), .alu_b_o(nalu_b), .alu_op_o(nalu_op),
      .alu_res_i(nalu_res), .busy_o(nbusy)
   );

   typedef struct {
      logic       id;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      int         hold;
      logic [7:0] exp_data;
      logic       exp_zero;
      logic [7:0] exp_nf;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      v0 = 1'b0; v1 = 1'b0;
      a0 = 8'h00; b0 = 8'h00; op0 = 3'd0;
      a1 = 8'h00; b1 = 8'h00; op1 = 3'd0;
   endtask

   task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op);
      if (id) begin
         v1 = 1'b1; a1 = a; b1 = b; op1 = op;
      end else begin
         v0 = 1'b1; a0 = a; b0 = b; op0 = op;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      @(negedge clk);
      drive(v.id, v.a, v.b, v.op);
      #1;
      chk({tag, "_ready"}, {30'd0, r1, r0}, v.id ? 32'd2 : 32'd1);
      @(posedge clk);
      #1;
      idle_inputs();
      chk({tag, "_exec"}, {30'd0, busy, rv}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, rv}, 32'd1);
      chk({tag, "_data"}, {24'd0, rdata}, {24'd0, v.exp_data});
      chk({tag, "_id"}, {31'd0, rid}, {31'd0, v.id});
      chk({tag, "_zero"}, {31'd0, rz}, {31'd0, v.exp_zero});
      chk({tag, "_nofix_data"}, {24'd0, nrdata}, {24'd0, v.exp_nf});
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold"}, {22'd0, rv, rid, rdata}, {22'd0, 1'b1, v.id, v.exp_data});
      end
      rsp_rdy = 1'b1;
      @(posedge clk);
      #1;
      rsp_rdy = 1'b0;
      chk({tag, "_done"}, {30'd0, busy, rv}, 32'd0);
   endtask

   task automatic reset_mid(input bit in_resp);
      string tag;
      tag = in_resp ? "rst_resp" : "rst_exec";
      @(negedge clk);
      drive(1'b0, 8'h33, 8'h44, 3'd6);
      @(posedge clk);
      #1;
      idle_inputs();
      if (in_resp) begin
         @(posedge clk);
         #1;
         chk({tag, "_pre_valid"}, {31'd0, rv}, 32'd1);
      end
      chk({tag, "_pre_alu"}, {16'd0, alu_a, alu_b}, 32'h3344);
      #1;
      rst_n = 1'b0;
      #1;
      chk({tag, "_flags"}, {29'd0, rv, busy, r0}, 32'd0);
      chk({tag, "_alu"}, {8'd0, alu_a, alu_b, 5'd0, alu_op}, 32'd0);
      chk({tag, "_rsp"}, {22'd0, rid, rz, rdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk({tag, "_no_stale"}, {30'd0, rv, busy}, 32'd0);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 8'h0F, 8'h01, 3'd0, 3, 8'h10, 1'b0, 8'h10};
      vecs[1]  = '{1'b1, 8'h01, 8'h02, 3'd1, 1, 8'hFF, 1'b0, 8'hFF};
      vecs[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 0, 8'h00, 1'b1, 8'h00};
      vecs[3]  = '{1'b1, 8'h5A, 8'h5A, 3'd7, 0, 8'h01, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 8'h5A, 8'h5B, 3'd7, 0, 8'h00, 1'b1, 8'h00};
      vecs[5]  = '{1'b1, 8'h81, 8'h01, 3'd2, 0, 8'h02, 1'b0, 8'h02};
      vecs[6]  = '{1'b0, 8'h81, 8'h01, 3'd3, 0, 8'h40, 1'b0, 8'h40};
      vecs[7]  = '{1'b1, 8'h81, 8'h08, 3'd2, 0, 8'h00, 1'b1, 8'h00};
      vecs[8]  = '{1'b0, 8'hF0, 8'h3C, 3'd4, 0, 8'h30, 1'b0, 8'h30};
      vecs[9]  = '{1'b1, 8'hF0, 8'h0F, 3'd5, 0, 8'hFF, 1'b0, 8'hFF};
      vecs[10] = '{1'b0, 8'hAA, 8'hFF, 3'd6, 0, 8'h55, 1'b0, 8'h55};
      vecs[11] = '{1'b1, 8'h81, 8'h09, 3'd3, 0, 8'h00, 1'b1, 8'h00};

      idle_inputs();
      rsp_rdy = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {28'd0, rv, busy, r0, r1}, 32'd0);
      chk("reset_alu", {8'd0, alu_a, alu_b, 5'd0, alu_op}, 32'd0);
      chk("reset_rsp", {22'd0, rid, rz, rdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i], i);

      reset_mid(1'b0);
      reset_mid(1'b1);

      // Both requesters valid from reset: expect 0,1,0,1 with 3 cycles between responses.
      begin
         int got;
         int last_cyc;
         logic [7:0] exp_d;
         got = 0;
         last_cyc = -1;
         @(negedge clk);
         drive(1'b0, 8'h10, 8'h20, 3'd0);
         drive(1'b1, 8'hAA, 8'h55, 3'd6);
         rsp_rdy = 1'b1;
         for (int c = 0; c < 30 && got < 4; c++) begin
            #1;
            if (r0 && r1) chk("contend_both_ready", {30'd0, r1, r0}, 32'd1);
            if (rv) begin
               exp_d = got[0] ? 8'hFF : 8'h30;
               chk($sformatf("contend%0d_id", got), {31'd0, rid}, {31'd0, got[0]});
               chk($sformatf("contend%0d_data", got), {24'd0, rdata}, {24'd0, exp_d});
               if (last_cyc >= 0) chk($sformatf("contend%0d_gap", got), c - last_cyc, 3);
               last_cyc = c;
               got++;
            end
            @(negedge clk);
         end
         chk("contend_count", got, 4);
         idle_inputs();
         rsp_rdy = 1'b0;
         repeat (4) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
